// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encoding, opcode count and default widths.
// Imported by the arbiter, the ALU and any decoder that issues ALU ops.
package alu_pkg;

    localparam int ALU_XLEN    = 64;
    localparam int ALU_OPW     = 4;
    localparam int ALU_NUM_OPS = 10;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_SRA  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_XOR  = 4'd9
    } alu_op_e;

    function automatic logic op_is_legal(input logic [ALU_OPW-1:0] op);
        return op < ALU_OPW'(ALU_NUM_OPS);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational XLEN-bit ALU. Shift amounts use the low log2(XLEN) bits of b;
// unknown opcodes produce zero.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int OPW  = ALU_OPW
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OPW-1:0]  op,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = b[SHW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        y = '0;
        case (op)
            OPW'(ALU_AND):  y = a & b;
            OPW'(ALU_OR):   y = a | b;
            OPW'(ALU_ADD):  y = a + b;
            OPW'(ALU_SLL):  y = a << shamt;
            OPW'(ALU_SRL):  y = a >> shamt;
            OPW'(ALU_SRA):  y = XLEN'($signed(a) >>> shamt);
            OPW'(ALU_SUB):  y = a - b;
            OPW'(ALU_SLTU): y = {{(XLEN-1){1'b0}}, lt_u};
            OPW'(ALU_SLT):  y = {{(XLEN-1){1'b0}}, lt_s};
            OPW'(ALU_XOR):  y = a ^ b;
            default:        y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered one-deep response slot per requester and valid/ready on both sides.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int OPW     = ALU_OPW,
    parameter int NUM_OPS = ALU_NUM_OPS
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp0_err,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,
    output logic            rsp1_err
);

    logic            elig0;
    logic            elig1;
    logic            grant0;
    logic            grant1;
    logic            last_grant;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_y;
    logic            alu_legal;
    logic [XLEN-1:0] result;

    // A slot being drained this cycle counts as free, so it can be refilled with no bubble.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_a  = grant1 ? req1_a  : req0_a;
    assign alu_b  = grant1 ? req1_b  : req0_b;
    assign alu_op = grant1 ? req1_op : req0_op;

    alu_share_arbiter_alu #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    assign alu_legal = alu_op < OPW'(NUM_OPS);
    assign result    = alu_legal ? alu_y : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= result;
            rsp0_err   <= ~alu_legal;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= result;
            rsp1_err   <= ~alu_legal;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [63:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [3:0]  req0_op, req1_op;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] alu_ref(input int op, input logic [63:0] a, input logic [63:0] b);
        int     sh;
        longint sa;
        longint sb;
        sh = int'(b % 64);
        sa = a;
        sb = b;
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a + b;
            3: return a << sh;
            4: return a >> sh;
            5: return sa >>> sh;
            6: return a - b;
            7: return (a < b) ? 64'd1 : 64'd0;
            8: return (sa < sb) ? 64'd1 : 64'd0;
            9: return a ^ b;
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural model: one result slot per port plus the port that last won.
    logic        m_valid [2];
    logic [63:0] m_data  [2];
    logic        m_err   [2];
    int          m_last = 1;

    initial begin
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0;
            m_data[p]  = '0;
            m_err[p]   = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic        v [2];
        logic        rr [2];
        logic [63:0] a [2];
        logic [63:0] b [2];
        int          op [2];
        logic        elig [2];
        int          winner;

        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                m_valid[p] = 1'b0;
                m_data[p]  = '0;
                m_err[p]   = 1'b0;
            end
            m_last = 1;
        end

        check("m rsp0_valid", rsp0_valid, m_valid[0]);
        check("m rsp0_data",  rsp0_data,  m_data[0]);
        check("m rsp0_err",   rsp0_err,   m_err[0]);
        check("m rsp1_valid", rsp1_valid, m_valid[1]);
        check("m rsp1_data",  rsp1_data,  m_data[1]);
        check("m rsp1_err",   rsp1_err,   m_err[1]);

        v[0] = req0_valid; rr[0] = rsp0_ready; a[0] = req0_a; b[0] = req0_b; op[0] = int'(req0_op);
        v[1] = req1_valid; rr[1] = rsp1_ready; a[1] = req1_a; b[1] = req1_b; op[1] = int'(req1_op);
        for (int p = 0; p < 2; p++) elig[p] = v[p] && (!m_valid[p] || rr[p]);

        if (elig[0] && elig[1]) winner = 1 - m_last;
        else if (elig[0])       winner = 0;
        else if (elig[1])       winner = 1;
        else                    winner = -1;

        check("m req0_ready", req0_ready, (winner == 0) ? 64'd1 : 64'd0);
        check("m req1_ready", req1_ready, (winner == 1) ? 64'd1 : 64'd0);

        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (winner == p) begin
                    m_valid[p] = 1'b1;
                    m_err[p]   = (op[p] >= ALU_NUM_OPS);
                    m_data[p]  = m_err[p] ? 64'd0 : alu_ref(op[p], a[p], b[p]);
                    m_last     = p;
                end else if (m_valid[p] && rr[p]) begin
                    m_valid[p] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1;
    endtask

    logic [63:0] sv_a [4] = '{64'hFFFF_FFFF_FFFF_FFF3, 64'hFFFF_FFFF_FFFF_FFF3,
                              64'hFFFF_FFFF_FFFF_FFF3, 64'd13};
    logic [63:0] sv_b [4] = '{64'd3, 64'd3, 64'd3, 64'd43};
    logic [3:0]  sv_op[4] = '{ALU_SUB, ALU_SRA, ALU_SLT, ALU_SLTU};
    logic [63:0] sv_ex[4] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1};

    initial begin
        logic acc0, acc1;
        rst_n = 0;
        idle_inputs();
        #2;
        check("reset rsp0_valid", rsp0_valid, 0);
        check("reset rsp1_valid", rsp1_valid, 0);
        check("reset rsp0_data",  rsp0_data,  0);
        check("reset rsp1_err",   rsp1_err,   0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        // contention straight after reset: port 0 first, then alternation
        req0_valid = 1; req0_op = ALU_SLL; req0_a = 2;  req0_b = 1;
        req1_valid = 1; req1_op = ALU_SRL; req1_a = 13; req1_b = 3;
        #1;
        check("cont c0 req0_ready", req0_ready, 1);
        check("cont c0 req1_ready", req1_ready, 0);
        step();
        check("cont c1 rsp0_valid", rsp0_valid, 1);
        check("cont c1 rsp0_data",  rsp0_data,  4);
        check("cont c1 req1_ready", req1_ready, 1);
        check("cont c1 req0_ready", req0_ready, 0);
        step();
        check("cont c2 rsp1_data",  rsp1_data,  1);
        check("cont c2 req0_ready", req0_ready, 1);
        step();
        check("cont c3 req1_ready", req1_ready, 1);
        idle_inputs();
        step();

        // lone requester
        req0_valid = 1; req0_op = ALU_ADD; req0_a = 4; req0_b = 2;
        #1;
        check("add req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        check("add rsp0_valid", rsp0_valid, 1);
        check("add rsp0_data",  rsp0_data,  6);
        check("add rsp0_err",   rsp0_err,   0);
        step();

        // signed ops on port 1, back to back
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1; req1_op = sv_op[i]; req1_a = sv_a[i]; req1_b = sv_b[i];
            step();
            check($sformatf("signed op%0d rsp1_data", i), rsp1_data, sv_ex[i]);
        end
        idle_inputs();
        step();

        // backpressure on port 0 while port 1 streams
        req0_valid = 1; req0_op = ALU_ADD; req0_a = 10; req0_b = 20; rsp0_ready = 0;
        step();
        req0_op = ALU_OR; req0_a = 1; req0_b = 2;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1; req1_op = ALU_ADD; req1_a = 64'(i); req1_b = 1;
            #1;
            check("bp req0_ready", req0_ready, 0);
            check("bp req1_ready", req1_ready, 1);
            step();
            check("bp rsp0_data", rsp0_data, 30);
            check("bp rsp1_data", rsp1_data, 64'(i + 1));
        end
        rsp0_ready = 1;
        #1;
        check("bp release req0_ready", req0_ready, 1);
        step();
        check("bp release rsp0_data", rsp0_data, 3);
        idle_inputs();
        step();

        // illegal opcode, then a legal one
        req0_valid = 1; req0_op = 4'd12; req0_a = 5; req0_b = 7;
        step();
        check("illegal rsp0_valid", rsp0_valid, 1);
        check("illegal rsp0_data",  rsp0_data,  0);
        check("illegal rsp0_err",   rsp0_err,   1);
        req0_op = ALU_XOR; req0_a = 13; req0_b = 3;
        step();
        check("xor rsp0_data", rsp0_data, 14);
        check("xor rsp0_err",  rsp0_err,  0);
        idle_inputs();
        step();

        // asynchronous reset with both slots full
        rsp0_ready = 0; rsp1_ready = 0;
        req0_valid = 1; req0_op = ALU_AND; req0_a = 3; req0_b = 1;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_op = ALU_OR; req1_a = 1; req1_b = 2;
        step();
        req1_valid = 0;
        check("pre-rst rsp0_valid", rsp0_valid, 1);
        check("pre-rst rsp1_valid", rsp1_valid, 1);
        #2;
        rst_n = 0;
        #1;
        check("async rst rsp0_valid", rsp0_valid, 0);
        check("async rst rsp1_valid", rsp1_valid, 0);
        req0_valid = 1; req1_valid = 1;
        step();
        rst_n = 1;
        #1;
        check("post-rst req0_ready", req0_ready, 1);
        check("post-rst req1_ready", req1_ready, 0);
        step();
        idle_inputs();
        step();

        // randomized traffic; requesters hold their op while waiting
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            @(posedge clk);
            #1;
            if (!(req0_valid && !acc0)) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
                req0_a     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 100));
                req0_b     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
                req1_a     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 100));
                req1_b     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
            end
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
        end
        idle_inputs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
